seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4, meaning consecutive legal transitions required to assert lock (range 1..15).
REQ-002 SHALL have parameter ERR_W, default 8, meaning width of the saturating error counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port q_in  input  4  observed counter value, asynchronous to clk, may glitch during ripple.
REQ-006 SHALL have port clr_err  input  1  synchronous clear of err_count.
REQ-007 SHALL have port locked  output  1  high while the sequence is being tracked correctly.
REQ-008 SHALL have port err  output  1  one-cycle pulse per illegal transition.
REQ-009 SHALL have port err_count  output  ERR_W  saturating count of illegal transitions.
REQ-010 SHALL have port expected  output  4  legal successor of the current accepted value (0 if current value is illegal).

Function
REQ-011 Legal successor table SHALL be 0->2, 2->5, 5->7, 7->8, 8->10, 10->9, 9->11, 11->8; values 1,3,4,6,12..15 have no successor.
REQ-012 q_in SHALL pass a 2-flop synchronizer; the synchronized value is q_s.
REQ-013 Accepted value cur SHALL update when q_s differs from cur (a "transition"); no transition, no checking.
REQ-014 A transition SHALL be legal only if q_s equals succ(cur); any other new value is illegal.
REQ-015 FSM states SHALL be UNLOCKED and LOCKED; reset enters UNLOCKED.
REQ-016 Legal transition: good_cnt SHALL increment (saturating at LOCK_COUNT); UNLOCKED -> LOCKED when good_cnt reaches LOCK_COUNT.
REQ-017 Illegal transition in any state: err SHALL pulse one cycle, good_cnt SHALL clear to 0, state SHALL become UNLOCKED, cur SHALL take the new value.
REQ-018 err, locked and expected SHALL be registered and reflect a transition one clk after cur updates; total q_in-to-err latency is 4 clk edges without filter (REQ-026).
REQ-019 err_count SHALL increment on each err pulse and saturate at 2^ERR_W-1 (no wrap).
REQ-020 clr_err SHALL zero err_count; clr_err coincident with an illegal transition SHALL leave err_count = 1.
REQ-021 The preamble 0->2->5->7 SHALL count as legal transitions toward lock.
REQ-022 An idle q_in (no transitions) SHALL hold locked, good_cnt and err_count indefinitely.

Reset
REQ-023 rst low SHALL immediately clear synchronizer stages, cur, good_cnt, state (UNLOCKED), locked, err, err_count to 0; expected SHALL read 2.
REQ-024 Reset mid-operation SHALL discard any in-flight transition; first transition after release is checked against cur = 0.
REQ-025 Deassertion SHALL take effect on the next rising clk; no transition is evaluated on that edge.

Configuration
REQ-026 Macro SEQ_CHK_GLITCH_FILTER_EN defined: a new q_s value SHALL be accepted only after being stable for 2 consecutive clk cycles, adding 1 cycle latency; ripple glitches shorter than 2 cycles SHALL be ignored.
REQ-027 Macro SEQ_CHK_GLITCH_FILTER_EN undefined: every q_s change SHALL be a transition immediately; filter logic SHALL be absent.

Verification
REQ-028 Reset, then q_in 0,2,5,7,8 each held 6 cycles -> locked rises after value 8 accepted (4th legal transition), err never pulses, expected = 10.
REQ-029 Locked, loop 8,10,9,11,8 for 3 full cycles -> locked stays 1, err_count = 0, expected follows 10,9,11,8.
REQ-030 Locked at value 10, drive 11 -> one err pulse, err_count = 1, locked = 0; then 8,10,9,11 -> relocks after 4th legal transition.
REQ-031 Drive 255+ illegal alternations 3,4 with ERR_W = 8 -> err_count saturates at 255; clr_err with simultaneous illegal transition -> err_count = 1.
REQ-032 Filter build: 1-cycle glitch 9->13->9 while locked at 9 -> no err, locked stays 1; non-filter build same stimulus -> two err pulses.
REQ-033 Assert rst low mid-loop at value 9 -> all outputs 0 (expected 2) within the same cycle; release, drive 2 -> legal, no err.

Source files
------------

// File: rtl/seq_checker.sv
// -----------------------------------------------------------------------------
// seq_checker
//   Watches a 4-bit counter value that arrives from another clock domain and
//   checks that it steps through the legal cycle
//     0 -> 2 -> 5 -> 7 -> 8 -> 10 -> 9 -> 11 -> 8 ...
//   The block locks after LOCK_COUNT consecutive legal steps. Each illegal step
//   produces a one-cycle err pulse, drops lock and bumps a saturating counter.
//
// Parameters
//   LOCK_COUNT  consecutive legal transitions needed to lock (1..15)
//   ERR_W       width of the saturating error counter
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active low
//   q_in       observed counter value (async, may glitch while rippling)
//   clr_err    synchronous clear of err_count
//   locked     high while the sequence is being tracked
//   err        one-cycle pulse per illegal transition
//   err_count  saturating count of illegal transitions
//   expected   legal successor of the accepted value (0 if it has none)
//
// Build option
//   SEQ_CHK_GLITCH_FILTER_EN  when defined, a synchronized value must hold for
//   two consecutive cycles before it is accepted. Pulses shorter than that are
//   dropped, and the latency grows by one cycle.
// -----------------------------------------------------------------------------
module seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       q_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       expected
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0]       LC      = 4'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] CNT_ONE = ERR_W'(1);

  // Legal successor; 0 marks "no successor".
  function automatic logic [3:0] succ(input logic [3:0] v);
    case (v)
      4'd0:    succ = 4'd2;
      4'd2:    succ = 4'd5;
      4'd5:    succ = 4'd7;
      4'd7:    succ = 4'd8;
      4'd8:    succ = 4'd10;
      4'd10:   succ = 4'd9;
      4'd9:    succ = 4'd11;
      4'd11:   succ = 4'd8;
      default: succ = 4'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] q_m, q_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m <= '0;
      q_s <= '0;
    end else begin
      q_m <= q_in;
      q_s <= q_m;
    end
  end

  // Candidate value presented to the transition detector.
  logic [3:0] cur;
  logic [3:0] q_cand;

`ifdef SEQ_CHK_GLITCH_FILTER_EN
  // A value is accepted only after q_s has shown it on two consecutive
  // cycles. Until then the candidate stays at cur, so no transition fires.
  logic [3:0] q_s_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_s_d <= '0;
    else      q_s_d <= q_s;
  end

  assign q_cand = (q_s == q_s_d) ? q_s : cur;
`else
  assign q_cand = q_s;
`endif

  // ---------------------------------------------------------------------------
  // Stage A: accept the new value and classify the step. The verdict is
  // registered, and stage B turns it into outputs on the following edge.
  // ---------------------------------------------------------------------------
  logic tr_vld, tr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur    <= '0;
      tr_vld <= 1'b0;
      tr_ok  <= 1'b0;
    end else begin
      cur    <= q_cand;
      tr_vld <= (q_cand != cur);
      tr_ok  <= (q_cand == succ(cur));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: lock FSM, good-step counter, err / err_count / expected
  // ---------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [3:0] good_cnt, good_nxt;
  logic       err_nxt;

  assign err_nxt = tr_vld & ~tr_ok;

  always_comb begin
    good_nxt = good_cnt;
    if (tr_vld) begin
      if (!tr_ok)          good_nxt = '0;
      else if (good_cnt < LC) good_nxt = good_cnt + 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UNLOCKED;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (tr_vld) begin
      if (!tr_ok)             state_nxt = UNLOCKED;
      else if (good_nxt >= LC) state_nxt = LOCKED;
    end
  end

  // Output decode; state is itself a register, so locked is glitch-free.
  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_cnt  <= '0;
      err       <= 1'b0;
      err_count <= '0;
      expected  <= 4'd2;
    end else begin
      good_cnt <= good_nxt;
      err      <= err_nxt;
      // cur already holds the value accepted on the previous edge.
      expected <= succ(cur);
      // If a clear lands on the same edge as an error, that error still
      // counts, so the counter restarts at 1.
      if (clr_err)
        err_count <= err_nxt ? CNT_ONE : '0;
      else if (err_nxt && (err_count != '1))
        err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;

  localparam int ERR_W      = 8;
  localparam int LOCK_COUNT = 4;
`ifdef SEQ_CHK_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int HOLD = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       q_in = '0;
  logic             clr_err = 1'b0;
  logic             locked, err;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       expected;

  seq_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err),
    .locked(locked), .err(err), .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             err;
    logic             locked;
    logic [3:0]       exp;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [3:0]       m_cur  = '0;
  int               m_good = 0;
  logic             m_lock = 1'b0;
  logic [ERR_W-1:0] m_cnt  = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  function automatic logic [3:0] succ(input logic [3:0] v);
    case (v)
      4'd0: return 4'd2;   4'd2:  return 4'd5;
      4'd5: return 4'd7;   4'd7:  return 4'd8;
      4'd8: return 4'd10;  4'd10: return 4'd9;
      4'd9: return 4'd11;  4'd11: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic model_step(input logic [3:0] v, input bit clr);
    exp_t e;
    bit tr, ok;
    tr = (v != m_cur);
    ok = (v == succ(m_cur));
    e.err = tr && !ok;
    if (tr) begin
      if (ok) begin
        if (m_good < LOCK_COUNT) m_good++;
        if (m_good >= LOCK_COUNT) m_lock = 1'b1;
      end else begin
        m_good = 0;
        m_lock = 1'b0;
      end
      m_cur = v;
    end
    if (clr) m_cnt = e.err ? ERR_W'(1) : '0;
    else if (e.err && m_cnt != '1) m_cnt = m_cnt + ERR_W'(1);
    e.locked = m_lock;
    e.exp    = succ(m_cur);
    e.cnt    = m_cnt;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".err"},       err,       e.err);
    chk({tag, ".locked"},    locked,    e.locked);
    chk({tag, ".expected"},  expected,  e.exp);
    chk({tag, ".err_count"}, err_count, e.cnt);
  endtask

  // Drive one value, check that err is still quiet one cycle early, then
  // check the result on the edge where it must appear.
  task automatic drive(input logic [3:0] v, input bit clr, input string tag);
    @(posedge clk); #1;
    q_in = v;
    model_step(v, clr);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk({tag, ".err_early"}, err, 1'b0);
    clr_err = clr;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check_out(tag);
    repeat (HOLD - LAT - 1) @(posedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.locked", locked, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.err_count", err_count, '0);
    chk("rst.expected", expected, 4'd2);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Preamble to lock
    drive(4'd0, 0, "pre0");
    drive(4'd2, 0, "pre2");
    drive(4'd5, 0, "pre5");
    drive(4'd7, 0, "pre7");
    drive(4'd8, 0, "pre8");

    // Locked loop, three times round
    for (int i = 0; i < 3; i++) begin
      drive(4'd10, 0, "loop10");
      drive(4'd9,  0, "loop9");
      drive(4'd11, 0, "loop11");
      drive(4'd8,  0, "loop8");
    end

    // Illegal step 10 -> 11, then relock
    drive(4'd10, 0, "ill10");
    drive(4'd11, 0, "ill11");
    drive(4'd8,  0, "rel8");
    drive(4'd10, 0, "rel10");
    drive(4'd9,  0, "rel9");
    drive(4'd11, 0, "rel11");

    // Saturation with 3 <-> 4 alternation
    for (int i = 0; i < 130; i++) begin
      drive(4'd3, 0, "sat3");
      drive(4'd4, 0, "sat4");
    end
    chk("sat.err_count", err_count, 8'hFF);

    // Clear coincident with an illegal step, then a plain clear
    drive(4'd3, 1, "clr_ill");
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    m_cnt = '0;
    chk("clr_only.err_count", err_count, m_cnt);

    // Lock again, ending at 9
    drive(4'd0,  0, "lk0");
    drive(4'd2,  0, "lk2");
    drive(4'd5,  0, "lk5");
    drive(4'd7,  0, "lk7");
    drive(4'd8,  0, "lk8");
    drive(4'd10, 0, "lk10");
    drive(4'd9,  0, "lk9");

    // Idle input holds everything
    repeat (40) @(posedge clk);
    #1;
    chk("idle.locked", locked, 1'b1);
    chk("idle.err_count", err_count, m_cnt);

    // One-cycle glitch 9 -> 13 -> 9
    @(posedge clk); #1 q_in = 4'd13;
    @(posedge clk); #1 q_in = 4'd9;
`ifdef SEQ_CHK_GLITCH_FILTER_EN
    repeat (6) @(posedge clk);
    #1;
    chk("glitch.err", err, 1'b0);
    chk("glitch.locked", locked, 1'b1);
    chk("glitch.err_count", err_count, m_cnt);
    chk("glitch.expected", expected, 4'd11);
`else
    model_step(4'd13, 0);
    model_step(4'd9, 0);
    repeat (3) @(posedge clk);
    #1 check_out("glitch_a");
    @(posedge clk);
    #1 check_out("glitch_b");
    repeat (4) @(posedge clk);
`endif

    // Relock at 9 (no-op for lock state in the filter build)
    drive(4'd11, 0, "r11");
    drive(4'd8,  0, "r8");
    drive(4'd10, 0, "r10");
    drive(4'd9,  0, "r9");

    // Reset mid-operation with a transition in flight
    @(posedge clk); #1 q_in = 4'd11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q_in = 4'd0;
    #1;
    chk("mrst.locked", locked, 1'b0);
    chk("mrst.err", err, 1'b0);
    chk("mrst.err_count", err_count, '0);
    chk("mrst.expected", expected, 4'd2);
    m_cur = '0; m_good = 0; m_lock = 1'b0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    drive(4'd2, 0, "post2");
    drive(4'd5, 0, "post5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
